pin_controller: RTL and testbench

- Bus responder on the shared command bus driven by the scheduler. The scheduler issues timed writes; this block decodes its own address window and drives one physical pin.
- Each instance controls one pin in one of four modes: static low, static high, square wave, or record.
- Record mode tristates the pin, samples it periodically and returns the samples through register reads.
- One instance per pin; instances sit in parallel on the bus.

---
 rtl/pin_controller_if.sv | 21 ++
 rtl/pin_controller.sv | 213 +++++++++++++++++++++
 tb/tb_pin_controller.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pin_controller_if.sv
// Command bus between the scheduler (master) and the pin responders (slave).
// Read data from all responders is OR-combined, so an idle slave drives zero.
interface pin_controller_if;
  logic [15:0] cmd_bus_addr;
  logic [31:0] cmd_bus_data;
  logic        cmd_bus_en;
  logic        cmd_bus_wr;
  logic        cmd_bus_rd;
  logic [31:0] rd_data;
  logic        rd_valid;

  modport master (
    output cmd_bus_addr, cmd_bus_data, cmd_bus_en, cmd_bus_wr, cmd_bus_rd,
    input  rd_data, rd_valid
  );

  modport slave (
    input  cmd_bus_addr, cmd_bus_data, cmd_bus_en, cmd_bus_wr, cmd_bus_rd,
    output rd_data, rd_valid
  );
endinterface

// File: rtl/pin_controller.sv
// Single-pin controller on the scheduler command bus. Drives the pin low,
// high or as a square wave, or tristates it and records periodic samples.
module pin_controller #(
  parameter logic [7:0] POSITION = 8'h00
) (
  input  logic             clk,
  input  logic             rst,
  pin_controller_if.slave  bus,
  input  logic             pin_in,
  output logic             pin_out,
  output logic             pin_oe
);

  typedef enum logic [2:0] {
    ST_LOW,
    ST_HIGH_STATIC,
    ST_WAVE_HI,
    ST_WAVE_LO,
    ST_RECORD
  } state_t;

  localparam logic [7:0] IDX_MODE       = 8'h00;
  localparam logic [7:0] IDX_HIGH_CYC   = 8'h01;
  localparam logic [7:0] IDX_LOW_CYC    = 8'h02;
  localparam logic [7:0] IDX_SAMPLE_DIV = 8'h03;
  localparam logic [7:0] IDX_SAMPLES    = 8'h10;
  localparam logic [7:0] IDX_SAMPLE_CNT = 8'h11;

  state_t      state_q, state_d;
  logic [1:0]  mode_q, mode_d;
  logic [31:0] high_cyc_q, high_cyc_d;
  logic [31:0] low_cyc_q, low_cyc_d;
  logic [31:0] sample_div_q, sample_div_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] div_q, div_d;
  logic [31:0] samples_q, samples_d;
  logic [31:0] sample_cnt_q, sample_cnt_d;
  logic        sync1_q, sync1_d;
  logic        sync2_q, sync2_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic        rd_valid_q, rd_valid_d;
  logic        pin_out_q, pin_out_d;
  logic        pin_oe_q, pin_oe_d;

  logic        sel;
  logic        wr_en;
  logic        rd_en;
  logic [7:0]  idx;
  logic        mode_commit;
  logic [31:0] high_last;
  logic [31:0] low_last;

  assign sel   = bus.cmd_bus_en && (bus.cmd_bus_addr[15:8] == POSITION);
  assign wr_en = sel && bus.cmd_bus_wr;
  // A simultaneous write wins; the read is dropped entirely.
  assign rd_en = sel && bus.cmd_bus_rd && !bus.cmd_bus_wr;
  assign idx   = bus.cmd_bus_addr[7:0];

  // Last count value of each wave phase; a length of 0 is treated as 1.
  assign high_last = (high_cyc_q == 32'd0) ? 32'd0 : high_cyc_q - 32'd1;
  assign low_last  = (low_cyc_q  == 32'd0) ? 32'd0 : low_cyc_q  - 32'd1;

  // Next-state logic: register writes, mode FSM, sampler and read response.
  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    high_cyc_d   = high_cyc_q;
    low_cyc_d    = low_cyc_q;
    sample_div_d = sample_div_q;
    cnt_d        = cnt_q;
    div_d        = div_q;
    samples_d    = samples_q;
    sample_cnt_d = sample_cnt_q;
    sync1_d      = pin_in;
    sync2_d      = sync1_q;
    rd_data_d    = 32'd0;
    rd_valid_d   = 1'b0;
    mode_commit  = 1'b0;

    if (wr_en) begin
      case (idx)
        IDX_MODE: begin
          mode_d      = bus.cmd_bus_data[1:0];
          mode_commit = 1'b1;
        end
        IDX_HIGH_CYC:   high_cyc_d   = bus.cmd_bus_data;
        IDX_LOW_CYC:    low_cyc_d    = bus.cmd_bus_data;
        IDX_SAMPLE_DIV: sample_div_d = bus.cmd_bus_data;
        default: ;
      endcase
    end

    if (mode_commit) begin
      // The commit restarts all timing; the recorded history is only
      // discarded when a new recording starts so it stays readable.
      cnt_d = 32'd0;
      div_d = 32'd0;
      case (bus.cmd_bus_data[1:0])
        2'd0: state_d = ST_LOW;
        2'd1: state_d = ST_HIGH_STATIC;
        2'd2: state_d = ST_WAVE_HI;
        default: begin
          state_d      = ST_RECORD;
          samples_d    = 32'd0;
          sample_cnt_d = 32'd0;
        end
      endcase
    end else begin
      case (state_q)
        ST_WAVE_HI: begin
          if (cnt_q >= high_last) begin
            state_d = ST_WAVE_LO;
            cnt_d   = 32'd0;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
        ST_WAVE_LO: begin
          if (cnt_q >= low_last) begin
            state_d = ST_WAVE_HI;
            cnt_d   = 32'd0;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
        ST_RECORD: begin
          // >= so that shrinking SAMPLE_DIV mid-recording still wraps.
          if (div_q >= sample_div_q) begin
            div_d     = 32'd0;
            samples_d = {samples_q[30:0], sync2_q};
            if (sample_cnt_q != 32'hFFFF_FFFF) begin
              sample_cnt_d = sample_cnt_q + 32'd1;
            end
          end else begin
            div_d = div_q + 32'd1;
          end
        end
        default: ;
      endcase
    end

    case (state_d)
      ST_HIGH_STATIC, ST_WAVE_HI: begin
        pin_out_d = 1'b1;
        pin_oe_d  = 1'b1;
      end
      ST_RECORD: begin
        pin_out_d = 1'b0;
        pin_oe_d  = 1'b0;
      end
      default: begin
        pin_out_d = 1'b0;
        pin_oe_d  = 1'b1;
      end
    endcase

    if (rd_en) begin
      rd_valid_d = 1'b1;
      case (idx)
        IDX_MODE:       rd_data_d = {30'd0, mode_q};
        IDX_HIGH_CYC:   rd_data_d = high_cyc_q;
        IDX_LOW_CYC:    rd_data_d = low_cyc_q;
        IDX_SAMPLE_DIV: rd_data_d = sample_div_q;
        IDX_SAMPLES:    rd_data_d = samples_q;
        IDX_SAMPLE_CNT: rd_data_d = sample_cnt_q;
        default:        rd_data_d = 32'd0;
      endcase
    end
  end

  // State register with asynchronous reset to the safe driven-low state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_LOW;
      mode_q       <= 2'd0;
      high_cyc_q   <= 32'd0;
      low_cyc_q    <= 32'd0;
      sample_div_q <= 32'd0;
      cnt_q        <= 32'd0;
      div_q        <= 32'd0;
      samples_q    <= 32'd0;
      sample_cnt_q <= 32'd0;
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      rd_data_q    <= 32'd0;
      rd_valid_q   <= 1'b0;
      pin_out_q    <= 1'b0;
      pin_oe_q     <= 1'b1;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      high_cyc_q   <= high_cyc_d;
      low_cyc_q    <= low_cyc_d;
      sample_div_q <= sample_div_d;
      cnt_q        <= cnt_d;
      div_q        <= div_d;
      samples_q    <= samples_d;
      sample_cnt_q <= sample_cnt_d;
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      rd_data_q    <= rd_data_d;
      rd_valid_q   <= rd_valid_d;
      pin_out_q    <= pin_out_d;
      pin_oe_q     <= pin_oe_d;
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign pin_out      = pin_out_q;
  assign pin_oe       = pin_oe_q;

endmodule

// File: tb/tb_pin_controller.sv
// Randomized self-checking bench for pin_controller at POSITION 8'h05.
module tb_pin_controller;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pin_in = 1'b0;
  logic pin_out;
  logic pin_oe;

  pin_controller_if bus();

  pin_controller #(.POSITION(8'h05)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .pin_in  (pin_in),
    .pin_out (pin_out),
    .pin_oe  (pin_oe)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Pin value seen at each rising edge, indexed by edge number.
  int cyc = 0;
  bit pin_hist [0:8191];
  int last_wr_edge = 0;

  always @(posedge clk) begin
    if (cyc < 8192) pin_hist[cyc] = pin_in;
    cyc = cyc + 1;
  end

  // One bus cycle; returns rd_valid/rd_data seen the cycle after the strobe.
  task automatic bus_xfer(input logic [15:0] addr, input logic [31:0] data,
                          input logic wr, input logic rd,
                          output logic v1, output logic [31:0] d1);
    @(negedge clk);
    bus.cmd_bus_addr = addr;
    bus.cmd_bus_data = data;
    bus.cmd_bus_en   = 1'b1;
    bus.cmd_bus_wr   = wr;
    bus.cmd_bus_rd   = rd;
    last_wr_edge     = cyc;
    @(negedge clk);
    bus.cmd_bus_en = 1'b0;
    bus.cmd_bus_wr = 1'b0;
    bus.cmd_bus_rd = 1'b0;
    v1 = bus.rd_valid;
    d1 = bus.rd_data;
    $display("xfer addr=%h data=%h wr=%0d rd=%0d -> valid=%0d rdata=%h",
             addr, data, wr, rd, v1, d1);
  endtask

  task automatic wr(input logic [15:0] addr, input logic [31:0] data);
    logic v;
    logic [31:0] d;
    bus_xfer(addr, data, 1'b1, 1'b0, v, d);
  endtask

  // Read; also returns the bus state one cycle later (must be idle again).
  task automatic rd(input logic [15:0] addr, output logic v1, output logic [31:0] d1,
                    output logic v2, output logic [31:0] d2);
    bus_xfer(addr, 32'd0, 1'b0, 1'b1, v1, d1);
    @(negedge clk);
    v2 = bus.rd_valid;
    d2 = bus.rd_data;
  endtask

  task automatic test_reset;
    logic v1, v2;
    logic [31:0] d1, d2;
    logic [7:0] idxs [6];
    idxs = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h10, 8'h11};
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (pin_out !== 1'b0 || pin_oe !== 1'b1) begin
      bad++;
      $display("FAIL reset_pins out=%b oe=%b want out=0 oe=1", pin_out, pin_oe);
    end
    total++;
    if (bus.rd_valid !== 1'b0 || bus.rd_data !== 32'd0) begin
      bad++;
      $display("FAIL reset_rd valid=%b data=%h want 0/0", bus.rd_valid, bus.rd_data);
    end
    rst = 1'b0;
    foreach (idxs[i]) begin
      rd({8'h05, idxs[i]}, v1, d1, v2, d2);
      total++;
      if (v1 !== 1'b1 || d1 !== 32'd0 || v2 !== 1'b0 || d2 !== 32'd0) begin
        bad++;
        $display("FAIL reset_read idx=%h got v=%b d=%h next v=%b d=%h want 1/0 then 0/0",
                 idxs[i], v1, d1, v2, d2);
      end
    end
  endtask

  task automatic test_decode;
    logic v1, v2;
    logic [31:0] d1, d2;
    wr(16'h0500, 32'd0);
    wr(16'h0600, 32'd1);
    repeat (2) begin
      total++;
      if (pin_out !== 1'b0) begin
        bad++;
        $display("FAIL decode_other_pos pin_out=%b want 0", pin_out);
      end
      @(negedge clk);
    end
    rd(16'h0600, v1, d1, v2, d2);
    total++;
    if (v1 !== 1'b0 || d1 !== 32'd0) begin
      bad++;
      $display("FAIL decode_other_read v=%b d=%h want 0/0", v1, d1);
    end
    wr(16'h0500, 32'd1);
    total++;
    if (pin_out !== 1'b1 || pin_oe !== 1'b1) begin
      bad++;
      $display("FAIL decode_high out=%b oe=%b want 1/1", pin_out, pin_oe);
    end
  endtask

  // Expected pin at cycle i after a square-wave commit, from phase arithmetic.
  task automatic run_wave(input int h, input int l);
    int he, le, cycles;
    logic exp;
    he = (h == 0) ? 1 : h;
    le = (l == 0) ? 1 : l;
    cycles = 2 * (he + le) + 3;
    wr(16'h0501, h);
    wr(16'h0502, l);
    wr(16'h0500, 32'd2);
    for (int i = 0; i < cycles; i++) begin
      exp = ((i % (he + le)) < he);
      total++;
      if (pin_out !== exp || pin_oe !== 1'b1) begin
        bad++;
        $display("FAIL wave h=%0d l=%0d cyc=%0d pin_out=%b oe=%b want %b/1",
                 h, l, i, pin_out, pin_oe, exp);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_wave;
    run_wave(3, 2);
    run_wave(0, 0);
    for (int r = 0; r < 6; r++) run_wave($urandom_range(0, 5), $urandom_range(0, 5));
  endtask

  // Record for n cycles, freeze, then compare against samples rebuilt
  // from the pin history (each sample sees the pin two edges earlier).
  task automatic run_record(input int dv, input int n, input bit random_pin);
    int e0, f, cnt;
    logic [31:0] exp_s;
    logic v1, v2;
    logic [31:0] d1, d2;
    wr(16'h0503, dv);
    if (!random_pin) pin_in = 1'b1;
    wr(16'h0500, 32'd3);
    e0 = last_wr_edge;
    total++;
    if (pin_oe !== 1'b0 || pin_out !== 1'b0) begin
      bad++;
      $display("FAIL record_tristate oe=%b out=%b want 0/0", pin_oe, pin_out);
    end
    for (int i = 0; i < n; i++) begin
      if (random_pin) pin_in = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    wr(16'h0500, 32'd0);
    f = last_wr_edge;
    exp_s = 32'd0;
    cnt = 0;
    for (int e = e0 + dv + 1; e < f; e += dv + 1) begin
      exp_s = {exp_s[30:0], pin_hist[e - 2]};
      cnt++;
    end
    rd(16'h0511, v1, d1, v2, d2);
    total++;
    if (v1 !== 1'b1 || d1 !== cnt || v2 !== 1'b0 || d2 !== 32'd0) begin
      bad++;
      $display("FAIL record_cnt div=%0d got v=%b d=%0d next v=%b d=%h want 1/%0d then 0/0",
               dv, v1, d1, v2, d2, cnt);
    end
    rd(16'h0510, v1, d1, v2, d2);
    total++;
    if (v1 !== 1'b1 || d1 !== exp_s) begin
      bad++;
      $display("FAIL record_samples div=%0d got v=%b d=%h want 1/%h", dv, v1, d1, exp_s);
    end
  endtask

  task automatic test_record;
    run_record(3, 40, 1'b0);
    for (int r = 0; r < 3; r++) run_record($urandom_range(0, 5), $urandom_range(30, 60), 1'b1);
    pin_in = 1'b0;
  endtask

  task automatic test_reads;
    logic v1, v2;
    logic [31:0] d1, d2, hv, lv, dv, nl;
    hv = $urandom; lv = $urandom; dv = $urandom; nl = $urandom;
    wr(16'h0501, hv);
    wr(16'h0502, lv);
    wr(16'h0503, dv);
    wr(16'h0504, $urandom);
    wr(16'h0520, $urandom);
    rd(16'h0501, v1, d1, v2, d2);
    total++;
    if (d1 !== hv) begin bad++; $display("FAIL read_high got %h want %h", d1, hv); end
    rd(16'h0502, v1, d1, v2, d2);
    total++;
    if (d1 !== lv) begin bad++; $display("FAIL read_low got %h want %h", d1, lv); end
    rd(16'h0503, v1, d1, v2, d2);
    total++;
    if (d1 !== dv) begin bad++; $display("FAIL read_div got %h want %h", d1, dv); end
    rd(16'h057F, v1, d1, v2, d2);
    total++;
    if (v1 !== 1'b1 || d1 !== 32'd0 || v2 !== 1'b0) begin
      bad++;
      $display("FAIL read_undef got v=%b d=%h next v=%b want 1/0 then 0", v1, d1, v2);
    end
    bus_xfer(16'h0502, nl, 1'b1, 1'b1, v1, d1);
    total++;
    if (v1 !== 1'b0 || d1 !== 32'd0) begin
      bad++;
      $display("FAIL wr_rd_collide got v=%b d=%h want 0/0", v1, d1);
    end
    rd(16'h0502, v1, d1, v2, d2);
    total++;
    if (d1 !== nl) begin bad++; $display("FAIL wr_rd_applied got %h want %h", d1, nl); end
    wr(16'h0500, 32'hFFFF_FFFE);
    rd(16'h0500, v1, d1, v2, d2);
    total++;
    if (d1 !== 32'd2) begin bad++; $display("FAIL read_mode got %h want 2", d1); end
  endtask

  task automatic test_rst_mid;
    logic v1, v2;
    logic [31:0] d1, d2;
    logic [7:0] idxs [6];
    idxs = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h10, 8'h11};
    wr(16'h0501, 32'd4);
    wr(16'h0502, 32'd3);
    wr(16'h0500, 32'd2);
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if (pin_out !== 1'b0 || pin_oe !== 1'b1) begin
      bad++;
      $display("FAIL rst_async out=%b oe=%b want 0/1", pin_out, pin_oe);
    end
    @(negedge clk);
    rst = 1'b0;
    foreach (idxs[i]) begin
      rd({8'h05, idxs[i]}, v1, d1, v2, d2);
      total++;
      if (v1 !== 1'b1 || d1 !== 32'd0) begin
        bad++;
        $display("FAIL rst_read idx=%h got v=%b d=%h want 1/0", idxs[i], v1, d1);
      end
    end
    total++;
    if (pin_out !== 1'b0 || pin_oe !== 1'b1) begin
      bad++;
      $display("FAIL rst_after out=%b oe=%b want 0/1", pin_out, pin_oe);
    end
  endtask

  initial begin
    bus.cmd_bus_addr = 16'd0;
    bus.cmd_bus_data = 32'd0;
    bus.cmd_bus_en   = 1'b0;
    bus.cmd_bus_wr   = 1'b0;
    bus.cmd_bus_rd   = 1'b0;
    test_reset();
    test_decode();
    test_wave();
    test_record();
    test_reads();
    test_rst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
